block_ram_loader: RTL

- Write-side master for the 32x32 tetromino block sprite RAM. The RAM is 14-bit addressed: 4-bit sprite id, 5-bit row, 5-bit column.
- Receives a start command carrying a sprite id. Then either streams 1024 pixels in from a valid/ready source (the MMIO/ROM copier), or floods the sprite with a constant color.
- Drives the sprite RAM write port: we, addr_w, pixel data.
- Sits between the processor-side loader and the block sprite sources. Only path by which sprite RAM contents change.

---
 rtl/block_pkg.sv | 26 ++
 rtl/block_raster_ctr.sv | 43 ++++
 rtl/block_raster_ctr_wrap_note.sv | 18 +
 rtl/block_ram_loader.sv | 131 +++++++++++++
 4 files changed

// File: rtl/block_pkg.sv
// Shared definitions for the tetromino block sprite RAM path:
// sprite geometry, block type encoding and the loader state encoding.
package block_pkg;

    localparam int SPR_SIZE_LOG2 = 5;
    localparam int SPR_PIXELS    = 1 << (2 * SPR_SIZE_LOG2);
    localparam int SID_W         = 4;
    localparam int PIXEL_CD      = 12;

    typedef enum logic [2:0] {
        BLK_I = 3'd0,
        BLK_O = 3'd1,
        BLK_T = 3'd2,
        BLK_S = 3'd3,
        BLK_Z = 3'd4,
        BLK_J = 3'd5,
        BLK_L = 3'd6
    } block_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } loader_state_e;

endpackage

// File: rtl/block_raster_ctr.sv
// Raster-order row/column/pixel counter for one square sprite; shared by the
// loader and any future readback logic.
module block_raster_ctr
    import block_pkg::*;
#(
    parameter int SIZE_LOG2 = SPR_SIZE_LOG2
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   clr_i,
    input  logic                   inc_i,
    output logic [SIZE_LOG2-1:0]   row_o,
    output logic [SIZE_LOG2-1:0]   col_o,
    output logic [2*SIZE_LOG2:0]   count_o,
    output logic                   last_o
);

    logic [SIZE_LOG2-1:0] row_q;
    logic [SIZE_LOG2-1:0] col_q;
    logic [2*SIZE_LOG2:0] count_q;

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset_i || clr_i) begin
            row_q   <= '0;
            col_q   <= '0;
            count_q <= '0;
        end else if (inc_i) begin
            col_q   <= col_q + 1'b1;
            count_q <= count_q + 1'b1;
            if (&col_q) begin
                row_q <= row_q + 1'b1;
            end
        end
    end

    assign row_o   = row_q;
    assign col_o   = col_q;
    assign count_o = count_q;
    assign last_o  = (&row_q) && (&col_q);

endmodule

// File: rtl/block_raster_ctr_wrap_note.sv
// Thin alias kept empty of logic: the loader top instantiates block_raster_ctr
// directly; this file only declares the write-address packing helper module.
module block_addr_pack
    import block_pkg::*;
#(
    parameter int SID_W_P   = SID_W,
    parameter int SIZE_LOG2 = SPR_SIZE_LOG2
) (
    input  logic [SID_W_P-1:0]             sid_i,
    input  logic [SIZE_LOG2-1:0]           row_i,
    input  logic [SIZE_LOG2-1:0]           col_i,
    output logic [SID_W_P+2*SIZE_LOG2-1:0] addr_o
);

    // Sprite id in the MSBs, then row, then column in the LSBs.
    assign addr_o = {sid_i, row_i, col_i};

endmodule

// File: rtl/block_ram_loader.sv
// Write-side master for the block sprite RAM: loads one sprite either from a
// valid/ready pixel stream or by flooding it with a constant colour.
module block_ram_loader
    import block_pkg::*;
#(
    parameter int CD        = PIXEL_CD,
    parameter int SID_W     = block_pkg::SID_W,
    parameter int SIZE_LOG2 = SPR_SIZE_LOG2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [SID_W-1:0]              sid_in,
    input  logic                          fill_en,
    input  logic [CD-1:0]                 fill_color,
    input  logic                          abort,
    input  logic                          s_valid,
    input  logic [CD-1:0]                 s_data,
    output logic                          s_ready,
    output logic                          we,
    output logic [SID_W+2*SIZE_LOG2-1:0]  addr_w,
    output logic [CD-1:0]                 pixel_out,
    output logic                          busy,
    output logic                          done,
    output logic [2*SIZE_LOG2:0]          count
);

    loader_state_e                 state_q;
    logic [SID_W-1:0]              sid_q;
    logic                          fill_q;
    logic [CD-1:0]                 color_q;
    logic                          we_q;
    logic [SID_W+2*SIZE_LOG2-1:0]  addr_q;
    logic [CD-1:0]                 pixel_q;
    logic                          busy_q;
    logic                          done_q;

    logic [SIZE_LOG2-1:0]          row;
    logic [SIZE_LOG2-1:0]          col;
    logic                          last;
    logic                          accept;
    logic                          ctr_clr;
    logic [CD-1:0]                 pixel_d;
    logic [SID_W+2*SIZE_LOG2-1:0]  addr_d;

    // abort outranks acceptance; in fill mode a pixel is taken every LOAD cycle.
    assign accept  = (state_q == LOAD) && !abort && (fill_q || s_valid);
    assign s_ready = (state_q == LOAD) && !abort && !fill_q;
    assign ctr_clr = (state_q == IDLE) && start;
    assign pixel_d = fill_q ? color_q : s_data;

    block_raster_ctr #(
        .SIZE_LOG2 (SIZE_LOG2)
    ) u_ctr (
        .clk     (clk),
        .reset_i (reset),
        .clr_i   (ctr_clr),
        .inc_i   (accept),
        .row_o   (row),
        .col_o   (col),
        .count_o (count),
        .last_o  (last)
    );

    block_addr_pack #(
        .SID_W_P   (SID_W),
        .SIZE_LOG2 (SIZE_LOG2)
    ) u_addr (
        .sid_i  (sid_q),
        .row_i  (row),
        .col_i  (col),
        .addr_o (addr_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sid_q   <= '0;
            fill_q  <= 1'b0;
            color_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            pixel_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sid_q   <= sid_in;
                        fill_q  <= fill_en;
                        color_q <= fill_color;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (accept) begin
                        we_q    <= 1'b1;
                        addr_q  <= addr_d;
                        pixel_q <= pixel_d;
                        if (last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign we        = we_q;
    assign addr_w    = addr_q;
    assign pixel_out = pixel_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
